// File: rtl/mem_dumper_pkg.sv
// Shared definitions for the memory image dumper: FSM encoding, word geometry
// and the size limit it shares with the UART program loader.
package mem_dumper_pkg;

  // Loader image size in words (512 KiB / 4); the dumper never reads more than this.
  localparam int unsigned LOADER_MAX_WORDS = 32'd131072;
  localparam int unsigned BYTES_PER_WORD   = 32'd4;
  localparam logic [1:0]  LAST_BYTE_IDX    = 2'(BYTES_PER_WORD - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  function automatic logic [31:0] clamp_words(input logic [31:0] nwords,
                                              input logic [31:0] max_words);
    logic [31:0] n_s;
    if (nwords > max_words) begin
      n_s = max_words;
    end else begin
      n_s = nwords;
    end
    return n_s;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return byte_addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_dumper_if.sv
// Bus bundle of the dumper: control request/status, main-memory read port and
// the byte stream towards the UART transmitter.
interface mem_dumper_if;
  logic        START;
  logic [31:0] BASE;
  logic [31:0] NWORDS;
  logic [31:0] MEM_ADDR;
  logic        MEM_RE;
  logic [31:0] MEM_RDATA;
  logic        MEM_RVALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        DONE;

  modport master (
    input  START, BASE, NWORDS, MEM_RDATA, MEM_RVALID, TX_READY,
    output MEM_ADDR, MEM_RE, TX_DATA, TX_VALID, BUSY, DONE
  );

  modport slave (
    output START, BASE, NWORDS, MEM_RDATA, MEM_RVALID, TX_READY,
    input  MEM_ADDR, MEM_RE, TX_DATA, TX_VALID, BUSY, DONE
  );
endinterface

// File: rtl/mem_dumper_word_serializer.sv
// Turns one 32-bit word into 4 bytes, LSB first, over valid/ready. 'last'
// flags the handshake of the final byte so the owner can fetch the next word.
module mem_dumper_word_serializer
  import mem_dumper_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        load,
  input  logic [31:0] word,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        last
);

  logic [31:0] buf_r;
  logic [1:0]  idx_r;
  logic        valid_r;
  logic        hs_s;

  assign hs_s  = valid_r & ready;
  // The current byte always sits in the low lane, so data comes straight from a flop.
  assign data  = buf_r[7:0];
  assign valid = valid_r;
  assign last  = hs_s & (idx_r == LAST_BYTE_IDX);

  // Word buffer, byte index and valid flag; shifts one byte out per handshake.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      buf_r   <= 32'd0;
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      buf_r   <= word;
      idx_r   <= 2'd0;
      valid_r <= 1'b1;
    end else if (hs_s) begin
      buf_r <= {8'd0, buf_r[31:8]};
      idx_r <= idx_r + 2'd1;
      if (idx_r == LAST_BYTE_IDX) begin
        valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_dumper.sv
// Memory image dumper: reads NWORDS words from BASE and streams them LSB-first
// to the UART transmitter, in the same byte order the program loader expects.
module mem_dumper
  import mem_dumper_pkg::*;
#(
  parameter int unsigned MAX_WORDS = LOADER_MAX_WORDS
)
(
  input  logic         CLK,
  input  logic         RST_X,
  mem_dumper_if.master bus
);

  state_e      state_r;
  state_e      state_s;
  logic [31:0] addr_r;
  logic [31:0] addr_s;
  logic [31:0] cnt_r;
  logic [31:0] cnt_s;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_addr_s;
  logic        mem_re_r;
  logic        mem_re_s;
  logic        busy_r;
  logic        busy_s;
  logic        done_r;
  logic        done_s;
  logic        load_s;
  logic [31:0] start_cnt_s;
  logic [7:0]  ser_data_s;
  logic        ser_valid_s;
  logic        ser_last_s;

  assign start_cnt_s = clamp_words(bus.NWORDS, MAX_WORDS);

  mem_dumper_word_serializer u_ser (
    .CLK   (CLK),
    .RST_X (RST_X),
    .load  (load_s),
    .word  (bus.MEM_RDATA),
    .data  (ser_data_s),
    .valid (ser_valid_s),
    .ready (bus.TX_READY),
    .last  (ser_last_s)
  );

  // Next-state and next-output logic of the dump sequencer.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    cnt_s      = cnt_r;
    mem_addr_s = mem_addr_r;
    mem_re_s   = 1'b0;
    busy_s     = busy_r;
    done_s     = done_r;
    load_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          addr_s = word_align(bus.BASE);
          cnt_s  = start_cnt_s;
          busy_s = 1'b1;
          done_s = 1'b0;
          if (start_cnt_s == 32'd0) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        mem_addr_s = addr_r;
        mem_re_s   = 1'b1;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        // Read data outside this state is stray and deliberately dropped.
        if (bus.MEM_RVALID) begin
          load_s  = 1'b1;
          state_s = ST_SEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_SEND: begin
        if (ser_last_s) begin
          cnt_s  = cnt_r - 32'd1;
          addr_s = addr_r + BYTES_PER_WORD;
          if (cnt_r == 32'd1) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_RD;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_FIN: begin
        busy_s  = 1'b0;
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Address/count bookkeeping and registered status/strobe outputs.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      addr_r     <= 32'd0;
      cnt_r      <= 32'd0;
      mem_addr_r <= 32'd0;
      mem_re_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      mem_addr_r <= mem_addr_s;
      mem_re_r   <= mem_re_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.MEM_ADDR = mem_addr_r;
  assign bus.MEM_RE   = mem_re_r;
  assign bus.TX_DATA  = ser_data_s;
  assign bus.TX_VALID = ser_valid_s;
  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;

endmodule

// File: tb/tb_mem_dumper.sv
// Scoreboard bench for mem_dumper: a reference model queues expected addresses
// and bytes per dump; a monitor pops and compares on every MEM_RE and TX handshake.
module tb_mem_dumper;

  localparam int unsigned MAXW = 20;

  logic CLK;
  logic RST_X;
  mem_dumper_if bus();

  mem_dumper #(.MAX_WORDS(MAXW)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus.master)
  );

  int          checks   = 0;
  int          failures = 0;
  int          re_count = 0;
  int          hs_cnt   = 0;
  bit          rand_ready = 1'b0;
  bit          spur_en    = 1'b0;
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 1;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mem [logic [31:0]];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC3A5_5A3C;
  endfunction

  // Reference model: word addresses step by 4 from the aligned base, bytes LSB first.
  task automatic push_expect(input logic [31:0] base, input logic [31:0] n, output int unsigned nw);
    logic [31:0] a;
    logic [31:0] w;
    nw = (n > MAXW) ? MAXW : n;
    for (int i = 0; i < int'(nw); i++) begin
      a = {base[31:2], 2'b00} + 32'(i) * 32'd4;
      w = mem_read(a);
      exp_addr.push_back(a);
      for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  // Memory responder with random latency; optionally injects stray read-valid pulses.
  initial begin : responder
    logic [31:0] pa;
    int          lat_cnt;
    bit          pend;
    pa = 32'd0; lat_cnt = 0; pend = 1'b0;
    forever begin
      @(negedge CLK);
      bus.MEM_RVALID = 1'b0;
      if (RST_X !== 1'b1) begin
        pend = 1'b0;
      end else if (pend) begin
        if (lat_cnt <= 1) begin
          bus.MEM_RVALID = 1'b1;
          bus.MEM_RDATA  = mem_read(pa);
          pend = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (bus.MEM_RE === 1'b1) begin
        pend    = 1'b1;
        pa      = bus.MEM_ADDR;
        lat_cnt = int'($urandom_range(lat_hi, lat_lo));
      end else if (spur_en && $urandom_range(7, 0) == 0) begin
        bus.MEM_RVALID = 1'b1;
        bus.MEM_RDATA  = $urandom;
      end
    end
  end

  // Drives TX_READY, then checks the handshake that the coming edge will perform.
  initial begin : monitor
    bit         prev_stall;
    bit         prev_re;
    logic [7:0] prev_data;
    prev_stall = 1'b0; prev_re = 1'b0; prev_data = 8'd0;
    forever begin
      @(negedge CLK);
      bus.TX_READY = rand_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
      if (RST_X !== 1'b1) begin
        prev_stall = 1'b0;
        prev_re    = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_hold_valid", 32'(bus.TX_VALID), 32'd1);
          check("tx_hold_data", 32'(bus.TX_DATA), 32'(prev_data));
        end
        if (bus.MEM_RE === 1'b1) begin
          re_count++;
          check("mem_re_width", 32'(prev_re), 32'd0);
          if (exp_addr.size() == 0) begin
            checks++; failures++;
            $display("FAIL mem_re_unexpected actual=0x%0h required=none", bus.MEM_ADDR);
          end else begin
            check("mem_addr", bus.MEM_ADDR, exp_addr.pop_front());
          end
        end
        if (bus.TX_VALID === 1'b1 && bus.TX_READY === 1'b1) begin
          hs_cnt++;
          if (exp_bytes.size() == 0) begin
            checks++; failures++;
            $display("FAIL tx_unexpected actual=0x%0h required=none", bus.TX_DATA);
          end else begin
            check("tx_byte", 32'(bus.TX_DATA), 32'(exp_bytes.pop_front()));
          end
        end
        prev_stall = (bus.TX_VALID === 1'b1) && (bus.TX_READY !== 1'b1);
        prev_data  = bus.TX_DATA;
        prev_re    = (bus.MEM_RE === 1'b1);
      end
    end
  end

  // One complete dump; with inject set, START is held high (random BASE/NWORDS) while BUSY.
  task automatic run_dump(input logic [31:0] base, input logic [31:0] n, input bit inject,
                          input int exp_cycles);
    int unsigned nw;
    int          cyc;
    int          re0;
    int          budget;
    push_expect(base, n, nw);
    re0    = re_count;
    budget = 40 + int'(nw) * 80;
    bus.BASE   = base;
    bus.NWORDS = n;
    bus.START  = 1'b1;
    tick();
    cyc = 1;
    check("done_clear", 32'(bus.DONE), 32'd0);
    check("busy_set", 32'(bus.BUSY), 32'd1);
    while (bus.DONE !== 1'b1 && cyc < budget) begin
      bus.START = inject && (bus.BUSY === 1'b1);
      if (inject) begin
        bus.BASE   = $urandom;
        bus.NWORDS = $urandom_range(9, 1);
      end
      tick();
      cyc++;
      if (cyc == 2 && nw != 0) check("start_to_re", 32'(bus.MEM_RE), 32'd1);
    end
    bus.START = 1'b0;
    check("dump_done", 32'(bus.DONE), 32'd1);
    check("busy_clear", 32'(bus.BUSY), 32'd0);
    if (exp_cycles >= 0) check("dump_cycles", 32'(cyc), 32'(exp_cycles));
    check("re_pulses", 32'(re_count - re0), 32'(nw));
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("addrs_left", 32'(exp_addr.size()), 32'd0);
    exp_bytes.delete();
    exp_addr.delete();
    tick();
    check("done_hold", 32'(bus.DONE), 32'd1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int unsigned nw;
    int          hs0;
    RST_X = 1'b0;
    bus.START = 1'b0; bus.BASE = 32'd0; bus.NWORDS = 32'd0;
    bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = 32'd0; bus.TX_READY = 1'b0;
    repeat (3) tick();
    check("rst_mem_addr", bus.MEM_ADDR, 32'd0);
    check("rst_mem_re", 32'(bus.MEM_RE), 32'd0);
    check("rst_tx_data", 32'(bus.TX_DATA), 32'd0);
    check("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    RST_X = 1'b1;
    tick();

    // Two known words, ready always high, latency 1: 2 + 2*(6+1) cycles.
    mem[32'h100] = 32'h4433_2211;
    mem[32'h104] = 32'h8877_6655;
    run_dump(32'h100, 32'd2, 1'b0, 16);

    // Empty dump: DONE two cycles after START, no reads, no bytes.
    run_dump(32'h2000, 32'd0, 1'b0, 2);

    // Random stalls, random latency, stray read-valid pulses.
    for (int i = 0; i < 16; i++) mem[32'h4000 + 32'(i) * 32'd4] = $urandom;
    lat_lo = 1; lat_hi = 7; rand_ready = 1'b1; spur_en = 1'b1;
    run_dump(32'h4000, 32'd16, 1'b0, -1);

    // Address wrap, unaligned base, word-count clamp.
    lat_lo = 1; lat_hi = 3;
    run_dump(32'hFFFF_FFFC, 32'd2, 1'b0, -1);
    run_dump(32'h0000_0103, 32'd1, 1'b0, -1);
    run_dump(32'h0000_0500, 32'hFFFF_FFFF, 1'b0, -1);
    run_dump(32'h0000_0600, 32'(MAXW + 1), 1'b0, -1);
    run_dump(32'h0000_0700, 32'(MAXW), 1'b0, -1);

    // START held through the whole dump including the FIN cycle, then a clean restart.
    run_dump(32'h800, 32'd3, 1'b1, -1);
    rand_ready = 1'b0; spur_en = 1'b0; lat_lo = 1; lat_hi = 1;
    run_dump(32'h900, 32'd2, 1'b0, 16);

    rand_ready = 1'b1; spur_en = 1'b1; lat_lo = 1; lat_hi = 5;
    for (int r = 0; r < 6; r++) begin
      run_dump($urandom, 32'($urandom_range(6, 0)), 1'($urandom_range(1, 0)), -1);
    end

    // Reset while the third byte of the first word is offered.
    rand_ready = 1'b0; spur_en = 1'b0; lat_lo = 1; lat_hi = 1;
    push_expect(32'hA00, 32'd2, nw);
    hs0 = hs_cnt;
    bus.BASE = 32'hA00; bus.NWORDS = 32'd2; bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int c = 0; c < 50 && hs_cnt < hs0 + 2; c++) tick();
    check("rst_reach_byte2", 32'(hs_cnt - hs0), 32'd2);
    @(posedge CLK);
    #1;
    check("pre_rst_valid", 32'(bus.TX_VALID), 32'd1);
    RST_X = 1'b0;
    #1;
    check("abort_mem_addr", bus.MEM_ADDR, 32'd0);
    check("abort_mem_re", 32'(bus.MEM_RE), 32'd0);
    check("abort_tx_data", 32'(bus.TX_DATA), 32'd0);
    check("abort_tx_valid", 32'(bus.TX_VALID), 32'd0);
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    exp_bytes.delete();
    exp_addr.delete();
    repeat (2) tick();
    RST_X = 1'b1;
    tick();
    run_dump(32'hB00, 32'd2, 1'b0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
